// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package memory_arbiter_pkg;

  // Access size encodings on both the requester and memory sides.
  localparam logic [1:0] size_byte    = 2'd0;
  localparam logic [1:0] size_half    = 2'd1;
  localparam logic [1:0] size_word    = 2'd2;
  localparam logic [1:0] size_illegal = 2'd3;

  // Operation encodings.
  localparam logic op_read  = 1'b0;
  localparam logic op_write = 1'b1;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    st_idle    = 2'd0,
    st_issue   = 2'd1,
    st_release = 2'd2,
    st_respond = 2'd3
  } state_e;

  // Keep only the bytes covered by the access size; the rest read as zero.
  function automatic logic [31:0] size_mask(input logic [31:0] data, input logic [1:0] size);
    logic [31:0] masked;
    case (size)
      size_byte: masked = {24'd0, data[7:0]};
      size_half: masked = {16'd0, data[15:0]};
      size_word: masked = data;
      default:   masked = 32'd0;
    endcase
    return masked;
  endfunction

endpackage

// File: rtl/memory_arbiter_select.sv
// Winner choice between two pending requests (round-robin or fixed priority).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
//   req_i        : pending request per requester (bit N = requester N)
//   last_grant_i : requester granted most recently
//   any_o        : at least one request pending
//   winner_o     : index of the requester to grant
module memory_arbiter_select #(
  parameter int unsigned fixed_priority = 0
) (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       any_o,
  output logic       winner_o
);

  always_comb begin
    any_o    = |req_i;
    winner_o = 1'b0;
    case (req_i)
      2'b10:   winner_o = 1'b1;
      // On a tie, round-robin hands the port to whoever did not have it last.
      2'b11:   winner_o = (fixed_priority != 0) ? 1'b0 : ~last_grant_i;
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one four-phase memory port between two four-phase requesters.
// Latency: requester ready rises 3 edges after enable is sampled (2 for an illegal size).
// Backpressure: waits indefinitely on memory_ready and on the requester dropping enable.
//   requesterN_* : address/data/size/operation/enable in, ready/data_in out (N = 0, 1)
//   memory_*     : latched address/data/size/operation and enable out, ready/data_in in
module memory_arbiter #(
  parameter int unsigned fixed_priority = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] requester0_address,
  input  logic [31:0] requester0_data_out,
  input  logic [1:0]  requester0_data_size,
  input  logic        requester0_operation,
  input  logic        requester0_enable,
  output logic        requester0_ready,
  output logic [31:0] requester0_data_in,
  input  logic [31:0] requester1_address,
  input  logic [31:0] requester1_data_out,
  input  logic [1:0]  requester1_data_size,
  input  logic        requester1_operation,
  input  logic        requester1_enable,
  output logic        requester1_ready,
  output logic [31:0] requester1_data_in,
  output logic [31:0] memory_address,
  output logic [31:0] memory_data_out,
  output logic [1:0]  memory_data_size,
  output logic        memory_operation,
  output logic        memory_enable,
  input  logic        memory_ready,
  input  logic [31:0] memory_data_in
);
  import memory_arbiter_pkg::*;

  state_e      state_q;
  logic        grant_q;
  logic        last_grant_q;
  // Set by reset: memory_ready may still be high from an abandoned access,
  // so no grant is made until it has been seen low in IDLE.
  logic        stale_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [1:0]  mem_size_q;
  logic        mem_op_q;
  logic        mem_en_q;
  logic [31:0] rdata_q;
  logic [1:0]  ready_q;
  logic [31:0] data0_q;
  logic [31:0] data1_q;

  logic [1:0]  req_vld;
  logic        any_req;
  logic        winner_d;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [1:0]  win_size;
  logic        win_op;
  logic        gnt_enable;

  assign req_vld = {requester1_enable & ~ready_q[1], requester0_enable & ~ready_q[0]};

  memory_arbiter_select #(
    .fixed_priority (fixed_priority)
  ) u_select (
    .req_i        (req_vld),
    .last_grant_i (last_grant_q),
    .any_o        (any_req),
    .winner_o     (winner_d)
  );

  always_comb begin
    win_addr  = requester0_address;
    win_wdata = requester0_data_out;
    win_size  = requester0_data_size;
    win_op    = requester0_operation;
    if (winner_d) begin
      win_addr  = requester1_address;
      win_wdata = requester1_data_out;
      win_size  = requester1_data_size;
      win_op    = requester1_operation;
    end
  end

  assign gnt_enable = grant_q ? requester1_enable : requester0_enable;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= st_idle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      stale_q      <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_size_q   <= '0;
      mem_op_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      rdata_q      <= '0;
      ready_q      <= '0;
      data0_q      <= '0;
      data1_q      <= '0;
    end else begin
      case (state_q)
        st_idle: begin
          if (!memory_ready) begin
            stale_q <= 1'b0;
          end
          if (any_req && (!stale_q || !memory_ready)) begin
            grant_q     <= winner_d;
            mem_addr_q  <= win_addr;
            mem_wdata_q <= win_wdata;
            mem_size_q  <= win_size;
            mem_op_q    <= win_op;
            rdata_q     <= '0;
            if (win_size == size_illegal) begin
              // No downstream access; answer with zero data.
              state_q <= st_respond;
            end else begin
              mem_en_q <= 1'b1;
              state_q  <= st_issue;
            end
          end
        end

        st_issue: begin
          if (memory_ready) begin
            if (mem_op_q == op_read) begin
              rdata_q <= size_mask(memory_data_in, mem_size_q);
            end
            mem_en_q <= 1'b0;
            state_q  <= st_release;
          end
        end

        st_release: begin
          if (!memory_ready) begin
            ready_q[grant_q] <= 1'b1;
            if (grant_q) data1_q <= rdata_q;
            else         data0_q <= rdata_q;
            state_q <= st_respond;
          end
        end

        st_respond: begin
          if (!ready_q[grant_q]) begin
            // Only reached on the illegal-size path, one cycle after the grant.
            ready_q[grant_q] <= 1'b1;
            if (grant_q) data1_q <= rdata_q;
            else         data0_q <= rdata_q;
          end else if (!gnt_enable) begin
            ready_q      <= '0;
            data0_q      <= '0;
            data1_q      <= '0;
            last_grant_q <= grant_q;
            state_q      <= st_idle;
          end
        end

        default: state_q <= st_idle;
      endcase
    end
  end

  assign requester0_ready   = ready_q[0];
  assign requester1_ready   = ready_q[1];
  assign requester0_data_in = data0_q;
  assign requester1_data_in = data1_q;
  assign memory_address     = mem_addr_q;
  assign memory_data_out    = mem_wdata_q;
  assign memory_data_size   = mem_size_q;
  assign memory_operation   = mem_op_q;
  assign memory_enable      = mem_en_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a round-robin and a fixed-priority instance share one
// byte-addressed memory model and one set of requester drivers, selected by sel_fp.
// Expected results are queued when a request is launched and compared on completion.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Requester-side stimulus.
  logic [31:0] addr0, wd0, addr1, wd1;
  logic [1:0]  sz0, sz1;
  logic        op0, op1, en0, en1;
  logic        sel_fp;

  // DUT outputs.
  logic        a_rdy0, a_rdy1, b_rdy0, b_rdy1;
  logic [31:0] a_din0, a_din1, b_din0, b_din1;
  logic [31:0] a_maddr, a_mdout, b_maddr, b_mdout;
  logic [1:0]  a_msize, b_msize;
  logic        a_mop, a_men, b_mop, b_men;

  // Selected view.
  logic        rdy0, rdy1, m_en, m_op;
  logic [31:0] din0, din1, m_addr, m_dout;
  logic [1:0]  m_size;

  // Memory model.
  logic        mem_ready;
  logic [31:0] mem_rdata, mem_word;
  logic [7:0]  ram [0:1023];
  logic        stall, hold, ovr_en, pl_en, prev_en;
  logic [31:0] ovr_val, pl_word, pulse_addr;
  logic [9:0]  pl_addr, ma;
  int          ext_len, ext_cnt, pulse_cnt;

  int order_q[$];
  int exp_order[$];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  memory_arbiter #(.fixed_priority(0)) u_dut_rr (
    .clock(clock), .reset_n(reset_n),
    .requester0_address(addr0), .requester0_data_out(wd0), .requester0_data_size(sz0),
    .requester0_operation(op0), .requester0_enable(en0 & ~sel_fp),
    .requester0_ready(a_rdy0), .requester0_data_in(a_din0),
    .requester1_address(addr1), .requester1_data_out(wd1), .requester1_data_size(sz1),
    .requester1_operation(op1), .requester1_enable(en1 & ~sel_fp),
    .requester1_ready(a_rdy1), .requester1_data_in(a_din1),
    .memory_address(a_maddr), .memory_data_out(a_mdout), .memory_data_size(a_msize),
    .memory_operation(a_mop), .memory_enable(a_men),
    .memory_ready(mem_ready & ~sel_fp), .memory_data_in(mem_rdata)
  );

  memory_arbiter #(.fixed_priority(1)) u_dut_fp (
    .clock(clock), .reset_n(reset_n),
    .requester0_address(addr0), .requester0_data_out(wd0), .requester0_data_size(sz0),
    .requester0_operation(op0), .requester0_enable(en0 & sel_fp),
    .requester0_ready(b_rdy0), .requester0_data_in(b_din0),
    .requester1_address(addr1), .requester1_data_out(wd1), .requester1_data_size(sz1),
    .requester1_operation(op1), .requester1_enable(en1 & sel_fp),
    .requester1_ready(b_rdy1), .requester1_data_in(b_din1),
    .memory_address(b_maddr), .memory_data_out(b_mdout), .memory_data_size(b_msize),
    .memory_operation(b_mop), .memory_enable(b_men),
    .memory_ready(mem_ready & sel_fp), .memory_data_in(mem_rdata)
  );

  assign rdy0   = sel_fp ? b_rdy0  : a_rdy0;
  assign rdy1   = sel_fp ? b_rdy1  : a_rdy1;
  assign din0   = sel_fp ? b_din0  : a_din0;
  assign din1   = sel_fp ? b_din1  : a_din1;
  assign m_en   = sel_fp ? b_men   : a_men;
  assign m_op   = sel_fp ? b_mop   : a_mop;
  assign m_addr = sel_fp ? b_maddr : a_maddr;
  assign m_dout = sel_fp ? b_mdout : a_mdout;
  assign m_size = sel_fp ? b_msize : a_msize;

  // Zero-delay memory: ready follows enable unless stalled, held, or stretched.
  assign ma        = m_addr[9:0];
  assign mem_ready = (m_en & ~stall) | hold | (ext_cnt != 0);
  assign mem_word  = {ram[ma + 10'd3], ram[ma + 10'd2], ram[ma + 10'd1], ram[ma]};
  assign mem_rdata = ovr_en ? ovr_val : mem_word;

  always @(posedge clock) begin
    if (pl_en) begin
      ram[pl_addr]         <= pl_word[7:0];
      ram[pl_addr + 10'd1] <= pl_word[15:8];
      ram[pl_addr + 10'd2] <= pl_word[23:16];
      ram[pl_addr + 10'd3] <= pl_word[31:24];
    end else if (m_en && m_op && mem_ready) begin
      ram[ma] <= m_dout[7:0];
      if (m_size != size_byte) ram[ma + 10'd1] <= m_dout[15:8];
      if (m_size == size_word) begin
        ram[ma + 10'd2] <= m_dout[23:16];
        ram[ma + 10'd3] <= m_dout[31:24];
      end
    end
    if (m_en) ext_cnt <= ext_len;
    else if (ext_cnt != 0) ext_cnt <= ext_cnt - 1;
    prev_en <= m_en;
    if (m_en && !prev_en) begin
      pulse_cnt  <= pulse_cnt + 1;
      pulse_addr <= m_addr;
    end
  end

  function automatic logic get_rdy(input int n);
    return (n == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic [31:0] get_din(input int n);
    return (n == 0) ? din0 : din1;
  endfunction

  task automatic preload_word(input logic [9:0] a, input logic [31:0] w);
    pl_addr = a;
    pl_word = w;
    pl_en = 1'b1;
    @(posedge clock); #1;
    pl_en = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  // One four-phase transaction; called #1 after a rising edge. lat counts edges from
  // launch until ready is seen (edge k is 1). chg_addr != 0 rewrites the address after edge k.
  task automatic do_req(input int n, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic op, input logic [31:0] chg_addr,
                        output logic [31:0] rd, output int lat,
                        output logic oth_rdy, output logic [31:0] oth_dat);
    int cnt;
    bit done;
    if (n == 0) begin addr0 = a; wd0 = wd; sz0 = sz; op0 = op; en0 = 1'b1; end
    else        begin addr1 = a; wd1 = wd; sz1 = sz; op1 = op; en1 = 1'b1; end
    cnt = 0;
    done = 1'b0;
    while (!done && cnt < 100) begin
      @(posedge clock); #1;
      cnt++;
      if (cnt == 1 && chg_addr != 0) begin
        if (n == 0) addr0 = chg_addr; else addr1 = chg_addr;
      end
      if (get_rdy(n)) done = 1'b1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL req%0d_ready_timeout ready=0 required=1", n);
    end
    rd      = get_din(n);
    lat     = cnt;
    oth_rdy = get_rdy(1 - n);
    oth_dat = get_din(1 - n);
    order_q.push_back(n);
    if (n == 0) en0 = 1'b0; else en1 = 1'b0;
    cnt = 0;
    while (get_rdy(n) && cnt < 100) begin
      @(posedge clock); #1;
      cnt++;
    end
    if (get_rdy(n)) begin
      checks++; failures++;
      $display("FAIL req%0d_release_timeout ready=1 required=0", n);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (m_en !== 1'b0) begin failures++; $display("FAIL reset_mem_enable got=%b exp=0", m_en); end
    checks++;
    if ({m_addr, m_dout, m_size, m_op} !== 67'd0) begin
      failures++; $display("FAIL reset_mem_fields got=%h exp=0", {m_addr, m_dout, m_size, m_op});
    end
    checks++;
    if ({rdy0, rdy1} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {rdy0, rdy1}); end
    checks++;
    if ({din0, din1} !== 64'd0) begin failures++; $display("FAIL reset_data_in got=%h exp=0", {din0, din1}); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (m_en !== 1'b0) begin failures++; $display("FAIL idle_after_reset got=%b exp=0", m_en); end
  endtask

  task automatic test_single_read();
    logic [31:0] rd, e, od;
    int lat, p0;
    logic orr;
    preload_word(10'h100, 32'h44332211);
    preload_word(10'h000, 32'h04030201);
    p0 = pulse_cnt;
    exp_q0.push_back(32'h44332211);
    do_req(0, 32'h100, 32'd0, size_word, op_read, 32'd0, rd, lat, orr, od);
    e = exp_q0.pop_front();
    checks++;
    if (rd !== e) begin failures++; $display("FAIL single_read_data got=%h exp=%h", rd, e); end
    checks++;
    if (lat != 3) begin failures++; $display("FAIL single_read_latency got=%0d exp=3", lat); end
    checks++;
    if (pulse_cnt - p0 != 1) begin failures++; $display("FAIL single_read_pulses got=%0d exp=1", pulse_cnt - p0); end
    checks++;
    if (pulse_addr !== 32'h100) begin failures++; $display("FAIL single_read_mem_address got=%h exp=00000100", pulse_addr); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] r0, r1, od0, od1, e, w;
    int l0, l1, got, want;
    logic or0, or1;
    apply_reset();
    order_q.delete();
    exp_order = '{0, 1};
    exp_q0.push_back(32'h04030201);
    exp_q1.push_back(32'h00000000);
    fork
      do_req(0, 32'h0,   32'd0,        size_word, op_read,  32'd0, r0, l0, or0, od0);
      do_req(1, 32'h200, 32'hDEADBEEF, size_word, op_write, 32'd0, r1, l1, or1, od1);
    join
    got = 0; want = 0;
    foreach (order_q[i])   got  = got * 10 + order_q[i] + 1;
    foreach (exp_order[i]) want = want * 10 + exp_order[i] + 1;
    checks++;
    if (got != want) begin failures++; $display("FAIL simul_order got=%0d exp=%0d", got, want); end
    e = exp_q0.pop_front();
    checks++;
    if (r0 !== e) begin failures++; $display("FAIL simul_read_data got=%h exp=%h", r0, e); end
    e = exp_q1.pop_front();
    checks++;
    if (r1 !== e) begin failures++; $display("FAIL simul_write_data_in got=%h exp=%h", r1, e); end
    checks++;
    if ({or0, od0} !== 33'd0) begin failures++; $display("FAIL simul_waiting_outputs got=%h exp=0", {or0, od0}); end
    w = {ram[10'h203], ram[10'h202], ram[10'h201], ram[10'h200]};
    checks++;
    if (w !== 32'hDEADBEEF) begin failures++; $display("FAIL simul_ram_write got=%h exp=deadbeef", w); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got0[$];
    logic [31:0] got1[$];
    logic [31:0] e;
    int got, want;
    apply_reset();
    order_q.delete();
    exp_order = '{0, 1, 0, 1};
    for (int i = 0; i < 2; i++) begin
      exp_q0.push_back(32'h44332211);
      exp_q1.push_back(32'hDEADBEEF);
    end
    fork
      begin
        logic [31:0] ra, oa; int la; logic sa;
        for (int i = 0; i < 2; i++) begin
          do_req(0, 32'h100, 32'd0, size_word, op_read, 32'd0, ra, la, sa, oa);
          got0.push_back(ra);
        end
      end
      begin
        logic [31:0] rb, ob; int lb; logic sb;
        for (int j = 0; j < 2; j++) begin
          do_req(1, 32'h200, 32'd0, size_word, op_read, 32'd0, rb, lb, sb, ob);
          got1.push_back(rb);
        end
      end
    join
    got = 0; want = 0;
    foreach (order_q[i])   got  = got * 10 + order_q[i] + 1;
    foreach (exp_order[i]) want = want * 10 + exp_order[i] + 1;
    checks++;
    if (got != want) begin failures++; $display("FAIL b2b_rr_order got=%0d exp=%0d", got, want); end
    for (int i = 0; i < 2; i++) begin
      e = exp_q0.pop_front();
      checks++;
      if (got0.size() <= i || got0[i] !== e) begin failures++; $display("FAIL b2b_req0_data idx=%0d exp=%h", i, e); end
      e = exp_q1.pop_front();
      checks++;
      if (got1.size() <= i || got1[i] !== e) begin failures++; $display("FAIL b2b_req1_data idx=%0d exp=%h", i, e); end
    end
  endtask

  task automatic test_fixed_priority();
    logic [31:0] r1, o1, e;
    int l1, got, want;
    logic s1;
    sel_fp = 1'b1;
    apply_reset();
    order_q.delete();
    exp_order = '{0, 0, 0, 1};
    exp_q1.push_back(32'h04030201);
    fork
      begin
        logic [31:0] ra, oa; int la; logic sa;
        for (int i = 0; i < 3; i++) do_req(0, 32'h100, 32'd0, size_word, op_read, 32'd0, ra, la, sa, oa);
      end
      do_req(1, 32'h0, 32'd0, size_word, op_read, 32'd0, r1, l1, s1, o1);
    join
    got = 0; want = 0;
    foreach (order_q[i])   got  = got * 10 + order_q[i] + 1;
    foreach (exp_order[i]) want = want * 10 + exp_order[i] + 1;
    checks++;
    if (got != want) begin failures++; $display("FAIL fixed_priority_order got=%0d exp=%0d", got, want); end
    e = exp_q1.pop_front();
    checks++;
    if (r1 !== e) begin failures++; $display("FAIL fixed_priority_req1_data got=%h exp=%h", r1, e); end
    sel_fp = 1'b0;
    apply_reset();
  endtask

  task automatic test_byte_read();
    logic [31:0] rd, od, e;
    int lat;
    logic orr;
    ovr_en = 1'b1;
    ovr_val = 32'hAABBCCDD;
    exp_q0.push_back(32'h000000DD);
    do_req(0, 32'h101, 32'd0, size_byte, op_read, 32'h3FC, rd, lat, orr, od);
    e = exp_q0.pop_front();
    checks++;
    if (rd !== e) begin failures++; $display("FAIL byte_read_data got=%h exp=%h", rd, e); end
    checks++;
    if (m_addr !== 32'h101) begin failures++; $display("FAIL byte_read_latched_address got=%h exp=00000101", m_addr); end
    exp_q1.push_back(32'h0000CCDD);
    do_req(1, 32'h102, 32'd0, size_half, op_read, 32'd0, rd, lat, orr, od);
    e = exp_q1.pop_front();
    checks++;
    if (rd !== e) begin failures++; $display("FAIL half_read_data got=%h exp=%h", rd, e); end
    ovr_en = 1'b0;
  endtask

  task automatic test_illegal_size();
    logic [31:0] rd, od, w;
    int lat, p0;
    logic orr;
    p0 = pulse_cnt;
    do_req(1, 32'h100, 32'h12345678, size_illegal, op_write, 32'd0, rd, lat, orr, od);
    checks++;
    if (lat != 2) begin failures++; $display("FAIL illegal_latency got=%0d exp=2", lat); end
    checks++;
    if (rd !== 32'd0) begin failures++; $display("FAIL illegal_data_in got=%h exp=0", rd); end
    checks++;
    if (pulse_cnt != p0) begin failures++; $display("FAIL illegal_mem_pulses got=%0d exp=0", pulse_cnt - p0); end
    w = {ram[10'h103], ram[10'h102], ram[10'h101], ram[10'h100]};
    checks++;
    if (w !== 32'h44332211) begin failures++; $display("FAIL illegal_ram_untouched got=%h exp=44332211", w); end
  endtask

  task automatic test_stretched_ready();
    logic [31:0] rd, od;
    int lat;
    logic orr;
    ext_len = 3;
    do_req(0, 32'h100, 32'd0, size_word, op_read, 32'd0, rd, lat, orr, od);
    ext_len = 0;
    checks++;
    if (lat != 6) begin failures++; $display("FAIL stretched_latency got=%0d exp=6", lat); end
    checks++;
    if (rd !== 32'h44332211) begin failures++; $display("FAIL stretched_data got=%h exp=44332211", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, od;
    int lat, p0;
    logic orr;
    stall = 1'b1;
    addr0 = 32'h100; sz0 = size_word; op0 = op_read; en0 = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (m_en !== 1'b1) begin failures++; $display("FAIL mid_issue_enable got=%b exp=1", m_en); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (m_en !== 1'b0) begin failures++; $display("FAIL reset_mid_enable got=%b exp=0", m_en); end
    checks++;
    if ({m_addr, m_dout, m_size, m_op, rdy0, rdy1, din0, din1} !== 133'd0) begin
      failures++; $display("FAIL reset_mid_outputs got=%h exp=0", {m_addr, m_size, m_op, rdy0, rdy1});
    end
    en0 = 1'b0;
    stall = 1'b0;
    hold = 1'b1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    p0 = pulse_cnt;
    fork
      do_req(1, 32'h100, 32'd0, size_word, op_read, 32'd0, rd, lat, orr, od);
      begin
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (pulse_cnt != p0) begin failures++; $display("FAIL stale_ready_ignored pulses=%0d exp=0", pulse_cnt - p0); end
        hold = 1'b0;
      end
    join
    checks++;
    if (rd !== 32'h44332211) begin failures++; $display("FAIL after_reset_read got=%h exp=44332211", rd); end
    checks++;
    if (pulse_cnt - p0 != 1) begin failures++; $display("FAIL after_reset_pulses got=%0d exp=1", pulse_cnt - p0); end
  endtask

  initial begin
    addr0 = '0; wd0 = '0; sz0 = '0; op0 = 1'b0; en0 = 1'b0;
    addr1 = '0; wd1 = '0; sz1 = '0; op1 = 1'b0; en1 = 1'b0;
    sel_fp = 1'b0; stall = 1'b0; hold = 1'b0; ovr_en = 1'b0; ovr_val = '0;
    pl_en = 1'b0; pl_addr = '0; pl_word = '0; ext_len = 0;
    ext_cnt = 0; pulse_cnt = 0; prev_en = 1'b0; pulse_addr = '0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_fixed_priority();
    test_byte_read();
    test_illegal_size();
    test_stretched_ready();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout time=%0t limit=500000", $time);
    $fatal(1, "bench watchdog expired");
  end

endmodule
